// File: rtl/demux8_pkg.sv
// Shared constants and output-state encoding for the 1-to-8 deserializer.
package demux8_pkg;
  localparam int unsigned SLOTS = 8;
  localparam int unsigned SEL_W = 3;

  typedef enum logic {
    OUT_EMPTY,
    OUT_FULL
  } out_state_e;
endpackage

// File: rtl/slot_counter.sv
// Slot index counter: wraps 0..SLOTS-1 on accept, loads 1 when a sync bit fills slot 0.
module slot_counter
  import demux8_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             load_i,
  output logic [SEL_W-1:0] sel_o,
  output logic             last_o
);

  logic [SEL_W-1:0] sel_q, sel_d;

  always_comb begin
    sel_d = sel_q;
    if (en_i) begin
      sel_d = load_i ? SEL_W'(1) : sel_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q <= '0;
    end else begin
      sel_q <= sel_d;
    end
  end

  assign sel_o  = sel_q;
  assign last_o = (sel_q == SEL_W'(SLOTS - 1));

endmodule

// File: rtl/demux1to8_deser.sv
// Serial-to-8-bit deserializer with sync-based framing and a valid/ready output register.
module demux1to8_deser
  import demux8_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             sync,
  output logic [SLOTS-1:0] q,
  output logic             q_valid,
  input  logic             q_ready,
  output logic [SEL_W-1:0] sel,
  output logic             frame_err
);

  out_state_e       state_q;
  logic [SLOTS-1:0] q_q;
  logic             ferr_q;
  // Slot 7 is never stored: the final bit goes straight into the word.
  logic [SLOTS-2:0] asm_q;
  logic [SLOTS-1:0] word_l, word_d;
  logic [SEL_W-1:0] slot;
  logic             last, accept, complete;

  slot_counter u_slot_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (accept),
    .load_i (sync),
    .sel_o  (sel),
    .last_o (last)
  );

  assign din_ready = !(last && (state_q == OUT_FULL) && !q_ready);
  assign accept    = din_valid && din_ready;
  assign complete  = accept && !sync && last;
  assign slot      = sync ? '0 : sel;

  always_comb begin
    word_l = {din, asm_q};
    word_d = word_l;
    if (MSB_FIRST) begin
      for (int unsigned i = 0; i < SLOTS; i++) begin
        word_d[i] = word_l[SLOTS-1-i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_q <= '0;
    end else if (accept && (slot != SEL_W'(SLOTS - 1))) begin
      asm_q[slot] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OUT_EMPTY;
      q_q     <= '0;
      ferr_q  <= 1'b0;
    end else begin
      ferr_q <= accept && sync && (sel != '0);
      case (state_q)
        OUT_EMPTY: begin
          if (complete) begin
            q_q     <= word_d;
            state_q <= OUT_FULL;
          end
        end
        OUT_FULL: begin
          if (complete) begin
            q_q <= word_d;
          end else if (q_ready) begin
            state_q <= OUT_EMPTY;
          end
        end
      endcase
    end
  end

  assign q         = q_q;
  assign q_valid   = (state_q == OUT_FULL);
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_demux1to8_deser.sv
// Directed and scoreboarded checks for demux1to8_deser (LSB-first and MSB-first instances).
module tb_demux1to8_deser;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       din = 1'b0;
  logic       din_valid = 1'b0;
  logic       sync = 1'b0;
  logic       q_ready = 1'b0;
  logic       din_ready, q_valid, frame_err;
  logic [7:0] q;
  logic [2:0] sel;
  logic       m_din_ready, m_q_valid, m_frame_err;
  logic [7:0] m_q;
  logic [2:0] m_sel;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  demux1to8_deser #(.MSB_FIRST(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .sync(sync), .q(q), .q_valid(q_valid), .q_ready(q_ready), .sel(sel), .frame_err(frame_err)
  );

  demux1to8_deser #(.MSB_FIRST(1'b1)) u_dut_msb (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(m_din_ready),
    .sync(sync), .q(m_q), .q_valid(m_q_valid), .q_ready(q_ready), .sel(m_sel), .frame_err(m_frame_err)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic d, input logic s);
    din = d; sync = s; din_valid = 1'b1;
    step();
    din_valid = 1'b0; sync = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input int unsigned nbits);
    for (int unsigned i = 0; i < nbits; i++) send(w[i], i == 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] cur, e;
    logic [2:0] msel;
    logic       mvalid, mready, acc, done;
    logic [7:0] exp_q[$];
    int         sent, got;

    // Reset state
    step(); step();
    chk("rst_q", q, 8'h00);
    chk("rst_q_valid", q_valid, 1'b0);
    chk("rst_sel", sel, 3'd0);
    chk("rst_din_ready", din_ready, 1'b1);
    chk("rst_frame_err", frame_err, 1'b0);
    rst_n = 1'b1;
    step();

    // Basic word, both bit orders
    q_ready = 1'b1;
    send_word(8'h4D, 8);
    chk("w1_q_valid", q_valid, 1'b1);
    chk("w1_q_lsb", q, 8'h4D);
    chk("w1_q_msb", m_q, 8'hB2);
    chk("w1_sel", sel, 3'd0);
    step();
    chk("w1_drained", q_valid, 1'b0);

    // Back-pressure at slot 7, then same-cycle drain and reload
    q_ready = 1'b0;
    send_word(8'hA5, 8);
    chk("bp_q_valid", q_valid, 1'b1);
    chk("bp_q_first", q, 8'hA5);
    send_word(8'h3C, 7);
    chk("bp_sel7", sel, 3'd7);
    chk("bp_q_held", q, 8'hA5);
    din = 1'b0; sync = 1'b0; din_valid = 1'b1;
    #1;
    chk("bp_din_ready_low", din_ready, 1'b0);
    step();
    chk("bp_sel_stuck", sel, 3'd7);
    chk("bp_q_still", q, 8'hA5);
    q_ready = 1'b1;
    #1;
    chk("bp_din_ready_high", din_ready, 1'b1);
    step();
    din_valid = 1'b0;
    chk("bp_q_new", q, 8'h3C);
    chk("bp_q_valid_kept", q_valid, 1'b1);
    chk("bp_sel_wrap", sel, 3'd0);
    step();
    chk("bp_drained", q_valid, 1'b0);

    // Frame restart mid-frame
    send(1'b1, 1'b1); send(1'b0, 1'b0); send(1'b1, 1'b0); send(1'b1, 1'b0);
    chk("fe_sel4", sel, 3'd4);
    chk("fe_no_err_yet", frame_err, 1'b0);
    send(1'b1, 1'b1);
    chk("fe_pulse", frame_err, 1'b1);
    chk("fe_sel1", sel, 3'd1);
    cur = 8'h5B;
    for (int i = 1; i < 8; i++) begin
      send(cur[i], 1'b0);
      if (i == 1) chk("fe_pulse_end", frame_err, 1'b0);
    end
    chk("fe_word", q, 8'h5B);
    chk("fe_word_valid", q_valid, 1'b1);
    send(1'b0, 1'b1);
    chk("fe_sync_sel0_no_err", frame_err, 1'b0);
    chk("fe_sync_sel0_sel", sel, 3'd1);
    for (int i = 1; i < 8; i++) send(1'b0, 1'b0);
    chk("fe_zero_word", q, 8'h00);
    step();

    // Random back-to-back words with random q_ready
    chk("rnd_start_sel", sel, 3'd0);
    msel = '0; mvalid = 1'b0; sent = 0; got = 0;
    cur = 8'($urandom);
    for (int cyc = 0; cyc < 3000 && got < 100; cyc++) begin
      q_ready   = 1'($urandom_range(0, 1));
      din_valid = (sent < 100);
      din       = cur[msel];
      sync      = (msel == 3'd0);
      #1;
      chk("rnd_q_valid", q_valid, mvalid);
      mready = !(msel == 3'd7 && mvalid && !q_ready);
      chk("rnd_din_ready", din_ready, mready);
      if (q_valid && q_ready) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        chk("rnd_q", q, e);
        got++;
      end
      acc  = din_valid && mready;
      done = acc && (msel == 3'd7);
      if (done) mvalid = 1'b1;
      else if (mvalid && q_ready) mvalid = 1'b0;
      if (done) begin
        exp_q.push_back(cur);
        sent++;
        cur = 8'($urandom);
      end
      if (acc) msel = msel + 3'd1;
      @(posedge clk);
      #1;
    end
    din_valid = 1'b0; sync = 1'b0;
    chk("rnd_words_got", 8'(got), 8'd100);
    chk("rnd_queue_empty", 8'(exp_q.size()), 8'd0);
    step();

    // Async reset mid-frame with a held word
    q_ready = 1'b0;
    send_word(8'hC3, 8);
    send_word(8'h00, 5);
    chk("ar_sel5", sel, 3'd5);
    chk("ar_held", q_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_q", q, 8'h00);
    chk("ar_q_valid", q_valid, 1'b0);
    chk("ar_sel", sel, 3'd0);
    chk("ar_din_ready", din_ready, 1'b1);
    chk("ar_frame_err", frame_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    q_ready = 1'b1;
    send_word(8'h96, 8);
    chk("ar_fresh_q", q, 8'h96);
    chk("ar_fresh_q_msb", m_q, 8'h69);
    chk("ar_fresh_valid", q_valid, 1'b1);
    chk("ar_fresh_no_err", frame_err, 1'b0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
